mem_axi_arbiter: RTL and testbench
==================================

# mem_axi_arbiter

Two-master to one-slave AXI4-Lite arbiter placed between the CPU instruction-fetch port (master 0), the CPU/DMA data port (master 1) and the memory controller's AXI4-Lite device port. It allows one transaction (read or write) in flight at a time, grants masters round-robin and routes every channel of the granted master to the slave. The slave only ever sees a single, well-formed AXI4-Lite stream.

## Interface
- No parameters; address/data fixed at 32 bits, strobes 4 bits, prot 3 bits.
- CLK  in  1  system clock; all logic on rising edge
- RSTb  in  1  reset, asynchronous and active-low
- mN_axi_awvalid/awaddr/awprot (N=0,1)  in  1/32/3  write address from master N
- mN_axi_awready  out  1  write address accepted
- mN_axi_wvalid/wdata/wstrb  in  1/32/4  write data from master N
- mN_axi_wready  out  1  write data accepted
- mN_axi_bvalid  out  1  write response to master N; mN_axi_bready in 1
- mN_axi_arvalid/araddr/arprot  in  1/32/3  read address from master N
- mN_axi_arready  out  1  read address accepted
- mN_axi_rvalid/rdata  out  1/32  read data to master N; mN_axi_rready in 1
- s_axi_* (aw*, w*, ar*, bready, rready)  out  as above  slave-side request channels
- s_axi_awready, wready, bvalid, arready, rvalid, rdata  in  as above  slave responses
- grant  out  2  one-hot owner ({m1,m0}); 2'b00 when idle
- busy  out  1  transaction in progress (state != IDLE)

## Operation
- States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP.
- Request per master: rd_req = arvalid; wr_req = awvalid | wvalid; req = rd_req | wr_req.
- IDLE: if any req, pick master: if both request, the one not equal to last_owner; else the requester. Within the chosen master, read has priority over write. Register owner, go to RD_ADDR or WR_REQ.
- RD_ADDR: s_axi_ar* = owner's ar*; owner's arready = s_axi_arready. On s ar handshake -> RD_DATA.
- RD_DATA: owner's rvalid/rdata = s_axi_rvalid/rdata; s_axi_rready = owner's rready. On r handshake -> IDLE, last_owner <= owner.
- WR_REQ: AW and W forwarded independently; flags aw_done, w_done set on respective handshakes, and each channel's valid to slave is masked once its flag is set. When both done (including same cycle) -> WR_RESP, flags cleared.
- WR_RESP: owner's bvalid = s_axi_bvalid; s_axi_bready = owner's bready. On b handshake -> IDLE, last_owner <= owner.
- Non-owner: all ready/valid outputs 0, rdata 32'h0. Non-owner requests are held off, never dropped (AXI valid stays asserted by master).
- Outputs not in the active channel of the current state: valid/ready 0, data buses 0 (muxes gated by state).
- A master whose request is a read while a write is also pending is granted the write on its next turn; no starvation because ownership alternates when both request.

## Timing
- Reset (RSTb low, any time, asynchronous): state IDLE, last_owner = m1 (so m0 wins first tie), aw_done = w_done = 0, grant = 0, busy = 0, every valid/ready output 0, all data outputs 0. Reset mid-transaction abandons it; slave is reset by the same RSTb.
- Arbitration costs exactly 1 cycle: request seen in IDLE at edge k, s_axi_arvalid/awvalid high from cycle k+1.
- Ready/valid paths from slave to owner and owner to slave are combinational through the mux (no added latency in channel states).
- Minimum read: 1 (arb) + 1 (ar) + 1 (r) = 3 cycles with zero-wait slave; back-to-back transactions separated by 1 IDLE cycle.
- Master deasserting valid before handshake is an AXI violation; behaviour undefined, not checked.

## Test plan
- Single read: m0 arvalid, araddr=32'h0000_0040, slave rdata=32'hDEAD_BEEF zero-wait -> s_axi_arvalid at cycle 1, m0_axi_rvalid with 32'hDEAD_BEEF at cycle 2, grant=2'b01 for cycles 1-2, back to IDLE.
- Contention: m0 and m1 both arvalid from reset, 4 reads each -> grants alternate m0,m1,m0,m1...; m1 rvalid/rdata never asserted during m0 ownership.
- Write, W before AW: m1 wvalid (wdata=32'h1234_5678, wstrb=4'b0011) 2 cycles before awvalid(addr=32'h1000_0000) -> slave sees W handshake then AW, wvalid masked after its handshake, m1_axi_bvalid after slave bvalid, one write only.
- Same-master read+write: m0 arvalid and awvalid/wvalid together -> read completes first, then (if m1 idle) m0 write granted next.
- Slave wait states: s_axi_arready delayed 3 cycles, rvalid delayed 5, m0 rready low 2 cycles -> state held, no duplicate handshake, busy=1 throughout.
- Async reset mid-RD_DATA: RSTb pulled low between edges -> all outputs 0 immediately, grant=0; after release, m0 request wins first tie.

Source files
------------

// File: rtl/mem_axi_arbiter_if.sv
// AXI4-Lite bundle (32-bit address/data, no response codes) shared by the
// arbiter's two master-facing ports and its single slave-facing port.
interface mem_axi_arbiter_if;
    logic        awvalid;
    logic        awready;
    logic [31:0] awaddr;
    logic [2:0]  awprot;
    logic        wvalid;
    logic        wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        bvalid;
    logic        bready;
    logic        arvalid;
    logic        arready;
    logic [31:0] araddr;
    logic [2:0]  arprot;
    logic        rvalid;
    logic        rready;
    logic [31:0] rdata;

    // Issuer of requests (CPU, DMA, or the arbiter toward memory)
    modport master (
        output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
               arvalid, araddr, arprot, rready,
        input  awready, wready, bvalid, arready, rvalid, rdata
    );

    modport slave (
        input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
               arvalid, araddr, arprot, rready,
        output awready, wready, bvalid, arready, rvalid, rdata
    );
endinterface

// File: rtl/mem_axi_arbiter.sv
// Two-master to one-slave AXI4-Lite arbiter: one transaction in flight,
// round-robin on contention, read-before-write within a master.
module mem_axi_arbiter (
    input  logic              clk_i,
    input  logic              rst_ni,
    mem_axi_arbiter_if.slave  m0_axi,
    mem_axi_arbiter_if.slave  m1_axi,
    mem_axi_arbiter_if.master s_axi,
    output logic [1:0]        grant_o,
    output logic              busy_o
);

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR_REQ,
        WR_RESP
    } state_e;

    state_e state_q, state_d;
    logic   owner_q, owner_d;
    logic   last_owner_q, last_owner_d;
    logic   aw_done_q, aw_done_d;
    logic   w_done_q, w_done_d;

    logic        req0, req1, pick, pick_rd;
    logic        sel_awvalid, sel_wvalid, sel_arvalid, sel_bready, sel_rready;
    logic [31:0] sel_awaddr, sel_wdata, sel_araddr;
    logic [2:0]  sel_awprot, sel_arprot;
    logic [3:0]  sel_wstrb;
    logic        aw_hs, w_hs;

    logic        own_awready, own_wready, own_arready, own_bvalid, own_rvalid;
    logic [31:0] own_rdata;

    assign req0 = m0_axi.arvalid | m0_axi.awvalid | m0_axi.wvalid;
    assign req1 = m1_axi.arvalid | m1_axi.awvalid | m1_axi.wvalid;

    always_comb begin
        sel_awvalid = owner_q ? m1_axi.awvalid : m0_axi.awvalid;
        sel_awaddr  = owner_q ? m1_axi.awaddr  : m0_axi.awaddr;
        sel_awprot  = owner_q ? m1_axi.awprot  : m0_axi.awprot;
        sel_wvalid  = owner_q ? m1_axi.wvalid  : m0_axi.wvalid;
        sel_wdata   = owner_q ? m1_axi.wdata   : m0_axi.wdata;
        sel_wstrb   = owner_q ? m1_axi.wstrb   : m0_axi.wstrb;
        sel_bready  = owner_q ? m1_axi.bready  : m0_axi.bready;
        sel_arvalid = owner_q ? m1_axi.arvalid : m0_axi.arvalid;
        sel_araddr  = owner_q ? m1_axi.araddr  : m0_axi.araddr;
        sel_arprot  = owner_q ? m1_axi.arprot  : m0_axi.arprot;
        sel_rready  = owner_q ? m1_axi.rready  : m0_axi.rready;
    end

    // Once a write channel has handshaken, its valid/ready are masked so the
    // slave never sees a second beat on that channel.
    assign aw_hs = (state_q == WR_REQ) & sel_awvalid & ~aw_done_q & s_axi.awready;
    assign w_hs  = (state_q == WR_REQ) & sel_wvalid  & ~w_done_q  & s_axi.wready;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        aw_done_d    = aw_done_q;
        w_done_d     = w_done_q;
        pick         = 1'b0;
        pick_rd      = 1'b0;
        case (state_q)
            IDLE: begin
                if (req0 | req1) begin
                    pick    = (req0 & req1) ? ~last_owner_q : req1;
                    pick_rd = pick ? m1_axi.arvalid : m0_axi.arvalid;
                    owner_d = pick;
                    state_d = pick_rd ? RD_ADDR : WR_REQ;
                end
            end
            RD_ADDR: begin
                if (sel_arvalid & s_axi.arready) state_d = RD_DATA;
            end
            RD_DATA: begin
                if (s_axi.rvalid & sel_rready) begin
                    state_d      = IDLE;
                    last_owner_d = owner_q;
                end
            end
            WR_REQ: begin
                if ((aw_done_q | aw_hs) & (w_done_q | w_hs)) begin
                    state_d   = WR_RESP;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end else begin
                    aw_done_d = aw_done_q | aw_hs;
                    w_done_d  = w_done_q | w_hs;
                end
            end
            WR_RESP: begin
                if (s_axi.bvalid & sel_bready) begin
                    state_d      = IDLE;
                    last_owner_d = owner_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            aw_done_q    <= aw_done_d;
            w_done_q     <= w_done_d;
        end
    end

    always_comb begin
        s_axi.awvalid = 1'b0;
        s_axi.awaddr  = 32'h0;
        s_axi.awprot  = 3'h0;
        s_axi.wvalid  = 1'b0;
        s_axi.wdata   = 32'h0;
        s_axi.wstrb   = 4'h0;
        s_axi.bready  = 1'b0;
        s_axi.arvalid = 1'b0;
        s_axi.araddr  = 32'h0;
        s_axi.arprot  = 3'h0;
        s_axi.rready  = 1'b0;
        own_awready   = 1'b0;
        own_wready    = 1'b0;
        own_arready   = 1'b0;
        own_bvalid    = 1'b0;
        own_rvalid    = 1'b0;
        own_rdata     = 32'h0;
        case (state_q)
            RD_ADDR: begin
                s_axi.arvalid = sel_arvalid;
                s_axi.araddr  = sel_araddr;
                s_axi.arprot  = sel_arprot;
                own_arready   = s_axi.arready;
            end
            RD_DATA: begin
                s_axi.rready = sel_rready;
                own_rvalid   = s_axi.rvalid;
                own_rdata    = s_axi.rdata;
            end
            WR_REQ: begin
                s_axi.awvalid = sel_awvalid & ~aw_done_q;
                s_axi.awaddr  = sel_awaddr;
                s_axi.awprot  = sel_awprot;
                s_axi.wvalid  = sel_wvalid & ~w_done_q;
                s_axi.wdata   = sel_wdata;
                s_axi.wstrb   = sel_wstrb;
                own_awready   = s_axi.awready & ~aw_done_q;
                own_wready    = s_axi.wready & ~w_done_q;
            end
            WR_RESP: begin
                s_axi.bready = sel_bready;
                own_bvalid   = s_axi.bvalid;
            end
            default: ;
        endcase
    end

    assign m0_axi.awready = own_awready & ~owner_q;
    assign m0_axi.wready  = own_wready  & ~owner_q;
    assign m0_axi.arready = own_arready & ~owner_q;
    assign m0_axi.bvalid  = own_bvalid  & ~owner_q;
    assign m0_axi.rvalid  = own_rvalid  & ~owner_q;
    assign m0_axi.rdata   = owner_q ? 32'h0 : own_rdata;

    assign m1_axi.awready = own_awready & owner_q;
    assign m1_axi.wready  = own_wready  & owner_q;
    assign m1_axi.arready = own_arready & owner_q;
    assign m1_axi.bvalid  = own_bvalid  & owner_q;
    assign m1_axi.rvalid  = own_rvalid  & owner_q;
    assign m1_axi.rdata   = owner_q ? own_rdata : 32'h0;

    assign busy_o  = (state_q != IDLE);
    assign grant_o = (state_q == IDLE) ? 2'b00 : (owner_q ? 2'b10 : 2'b01);

endmodule

// File: tb/tb_mem_axi_arbiter.sv
// Directed bench for mem_axi_arbiter: the bench plays both masters and the
// slave, stepping one clock at a time and checking outputs between edges.
module tb_mem_axi_arbiter;
    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic [1:0] grant_o;
    logic       busy_o;
    int         n_chk = 0;
    int         n_fail = 0;

    mem_axi_arbiter_if m0_if ();
    mem_axi_arbiter_if m1_if ();
    mem_axi_arbiter_if s_if ();

    mem_axi_arbiter dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .m0_axi (m0_if),
        .m1_axi (m1_if),
        .s_axi  (s_if),
        .grant_o(grant_o),
        .busy_o (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        #0;
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_ni = 1'b0;
        {m0_if.awvalid, m0_if.wvalid, m0_if.arvalid, m0_if.bready, m0_if.rready} = '0;
        {m1_if.awvalid, m1_if.wvalid, m1_if.arvalid, m1_if.bready, m1_if.rready} = '0;
        m0_if.awaddr = '0; m0_if.awprot = '0; m0_if.wdata = '0; m0_if.wstrb = '0;
        m0_if.araddr = '0; m0_if.arprot = '0;
        m1_if.awaddr = '0; m1_if.awprot = '0; m1_if.wdata = '0; m1_if.wstrb = '0;
        m1_if.araddr = '0; m1_if.arprot = '0;
        s_if.awready = 0; s_if.wready = 0; s_if.bvalid = 0;
        s_if.arready = 0; s_if.rvalid = 0; s_if.rdata = '0;

        // reset state
        #12;
        chk("rst_grant", grant_o, 2'b00);
        chk("rst_busy", busy_o, 0);
        chk("rst_s_arvalid", s_if.arvalid, 0);
        chk("rst_s_awvalid", s_if.awvalid, 0);
        chk("rst_m0_rdata", m0_if.rdata, 0);
        tick();
        rst_ni = 1'b1;

        // single read on m0, zero-wait slave
        m0_if.rready = 1; m1_if.rready = 1;
        m0_if.arvalid = 1; m0_if.araddr = 32'h0000_0040;
        #1 chk("rd1_idle_arvalid", s_if.arvalid, 0);
        tick();
        s_if.arready = 1;
        #1;
        chk("rd1_grant_c1", grant_o, 2'b01);
        chk("rd1_s_arvalid", s_if.arvalid, 1);
        chk("rd1_s_araddr", s_if.araddr, 32'h0000_0040);
        chk("rd1_m0_arready", m0_if.arready, 1);
        chk("rd1_m1_arready", m1_if.arready, 0);
        tick();
        m0_if.arvalid = 0; s_if.arready = 0;
        s_if.rvalid = 1; s_if.rdata = 32'hDEAD_BEEF;
        #1;
        chk("rd1_grant_c2", grant_o, 2'b01);
        chk("rd1_m0_rvalid", m0_if.rvalid, 1);
        chk("rd1_m0_rdata", m0_if.rdata, 32'hDEAD_BEEF);
        chk("rd1_m1_rvalid", m1_if.rvalid, 0);
        chk("rd1_m1_rdata", m1_if.rdata, 0);
        chk("rd1_s_rready", s_if.rready, 1);
        chk("rd1_s_arvalid_off", s_if.arvalid, 0);
        tick();
        s_if.rvalid = 0;
        #1;
        chk("rd1_idle_busy", busy_o, 0);
        chk("rd1_idle_grant", grant_o, 2'b00);

        // contention from reset: grants alternate m0, m1, ...
        rst_ni = 0; tick(); rst_ni = 1;
        m0_if.arvalid = 1; m0_if.araddr = 32'h0000_0100;
        m1_if.arvalid = 1; m1_if.araddr = 32'h0000_0200;
        for (int i = 0; i < 8; i++) begin
            tick();
            s_if.arready = 1;
            #1;
            chk("cont_grant", grant_o, (i % 2 == 0) ? 2'b01 : 2'b10);
            chk("cont_araddr", s_if.araddr, (i % 2 == 0) ? 32'h0000_0100 : 32'h0000_0200);
            tick();
            s_if.arready = 0; s_if.rvalid = 1; s_if.rdata = 32'hA000_0000 + i;
            #1;
            if (i % 2 == 0) begin
                chk("cont_m0_rdata", m0_if.rdata, 32'hA000_0000 + i);
                chk("cont_m1_rvalid", m1_if.rvalid, 0);
                chk("cont_m1_rdata", m1_if.rdata, 0);
            end else begin
                chk("cont_m1_rdata", m1_if.rdata, 32'hA000_0000 + i);
                chk("cont_m0_rvalid", m0_if.rvalid, 0);
            end
            tick();
            s_if.rvalid = 0;
            if (i == 7) begin m0_if.arvalid = 0; m1_if.arvalid = 0; end
            #1 chk("cont_idle_busy", busy_o, 0);
        end

        // m1 write, W arrives two cycles before AW
        m1_if.wvalid = 1; m1_if.wdata = 32'h1234_5678; m1_if.wstrb = 4'b0011;
        m1_if.bready = 1;
        tick();
        s_if.wready = 1;
        #1;
        chk("wr_grant", grant_o, 2'b10);
        chk("wr_s_wvalid", s_if.wvalid, 1);
        chk("wr_s_wdata", s_if.wdata, 32'h1234_5678);
        chk("wr_s_wstrb", s_if.wstrb, 4'b0011);
        chk("wr_s_awvalid_early", s_if.awvalid, 0);
        chk("wr_m1_wready", m1_if.wready, 1);
        tick();
        s_if.wready = 0;
        #1 chk("wr_s_wvalid_masked", s_if.wvalid, 0);
        tick();
        m1_if.wvalid = 0;
        m1_if.awvalid = 1; m1_if.awaddr = 32'h1000_0000;
        s_if.awready = 1;
        #1;
        chk("wr_s_awvalid", s_if.awvalid, 1);
        chk("wr_s_awaddr", s_if.awaddr, 32'h1000_0000);
        chk("wr_s_wvalid_still_masked", s_if.wvalid, 0);
        chk("wr_m1_awready", m1_if.awready, 1);
        tick();
        m1_if.awvalid = 0; s_if.awready = 0;
        #1;
        chk("wr_resp_busy", busy_o, 1);
        chk("wr_resp_awvalid", s_if.awvalid, 0);
        chk("wr_resp_bvalid_pre", m1_if.bvalid, 0);
        chk("wr_resp_bready", s_if.bready, 1);
        tick();
        s_if.bvalid = 1;
        #1;
        chk("wr_m1_bvalid", m1_if.bvalid, 1);
        chk("wr_m0_bvalid", m0_if.bvalid, 0);
        tick();
        s_if.bvalid = 0;
        #1;
        chk("wr_idle_busy", busy_o, 0);
        chk("wr_only_once", s_if.wvalid | s_if.awvalid, 0);

        // m0 read and write together: read first, then write
        m0_if.arvalid = 1; m0_if.araddr = 32'h0000_0300;
        m0_if.awvalid = 1; m0_if.awaddr = 32'h0000_0400;
        m0_if.wvalid = 1; m0_if.wdata = 32'hCAFE_F00D; m0_if.wstrb = 4'hF;
        m0_if.bready = 1;
        tick();
        s_if.arready = 1;
        #1;
        chk("rw_grant", grant_o, 2'b01);
        chk("rw_read_first", s_if.arvalid, 1);
        chk("rw_no_aw", s_if.awvalid, 0);
        chk("rw_no_w", s_if.wvalid, 0);
        tick();
        m0_if.arvalid = 0; s_if.arready = 0;
        s_if.rvalid = 1; s_if.rdata = 32'h5555_AAAA;
        #1 chk("rw_rdata", m0_if.rdata, 32'h5555_AAAA);
        tick();
        s_if.rvalid = 0;
        tick();
        s_if.awready = 1; s_if.wready = 1;
        #1;
        chk("rw_wr_grant", grant_o, 2'b01);
        chk("rw_s_awaddr", s_if.awaddr, 32'h0000_0400);
        chk("rw_s_wvalid", s_if.wvalid, 1);
        chk("rw_m0_awready", m0_if.awready, 1);
        chk("rw_m0_wready", m0_if.wready, 1);
        tick();
        m0_if.awvalid = 0; m0_if.wvalid = 0;
        s_if.awready = 0; s_if.wready = 0; s_if.bvalid = 1;
        #1;
        chk("rw_same_cycle_resp", m0_if.bvalid, 1);
        chk("rw_m1_bvalid", m1_if.bvalid, 0);
        tick();
        s_if.bvalid = 0;
        #1 chk("rw_idle", busy_o, 0);

        // slave wait states and master back-pressure
        m0_if.arvalid = 1; m0_if.araddr = 32'h0000_0500;
        tick();
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("ws_arvalid_held", s_if.arvalid, 1);
            chk("ws_arready_low", m0_if.arready, 0);
            chk("ws_busy", busy_o, 1);
            tick();
        end
        s_if.arready = 1;
        #1 chk("ws_arready", m0_if.arready, 1);
        tick();
        m0_if.arvalid = 0; s_if.arready = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("ws_no_rvalid", m0_if.rvalid, 0);
            chk("ws_no_dup_ar", s_if.arvalid, 0);
            chk("ws_busy", busy_o, 1);
            tick();
        end
        s_if.rvalid = 1; s_if.rdata = 32'h0BAD_F00D; m0_if.rready = 0;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("ws_rvalid_held", m0_if.rvalid, 1);
            chk("ws_rready_low", s_if.rready, 0);
            tick();
        end
        m0_if.rready = 1;
        #1;
        chk("ws_rdata", m0_if.rdata, 32'h0BAD_F00D);
        chk("ws_rready", s_if.rready, 1);
        tick();
        s_if.rvalid = 0;
        #1 chk("ws_idle", busy_o, 0);

        // asynchronous reset in the middle of an m1 read
        m1_if.arvalid = 1; m1_if.araddr = 32'h0000_0600;
        tick();
        s_if.arready = 1;
        tick();
        m1_if.arvalid = 0; s_if.arready = 0;
        s_if.rvalid = 1; s_if.rdata = 32'h7777_8888;
        #1 chk("ar_pre_rvalid", m1_if.rvalid, 1);
        #1 rst_ni = 0;
        #1;
        chk("ar_grant", grant_o, 2'b00);
        chk("ar_busy", busy_o, 0);
        chk("ar_m1_rvalid", m1_if.rvalid, 0);
        chk("ar_m1_rdata", m1_if.rdata, 0);
        chk("ar_s_rready", s_if.rready, 0);
        s_if.rvalid = 0;
        tick();
        rst_ni = 1;
        m0_if.arvalid = 1; m1_if.arvalid = 1;
        tick();
        #1 chk("ar_first_tie", grant_o, 2'b01);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
